// File: rtl/cmp_stream.sv
// cmp_stream: two-stage pipelined magnitude comparator with a valid/ready stream
// interface, a per-beat signed/unsigned mode, and optional per-frame result tallies.
//
// Optional feature macro: CMP_TALLY_EN
//   defined   -> saturating gt/eq/lt counters plus a one-cycle frame-summary pulse
//   undefined -> no counters; sum_valid and sum_* are tied to 0
//
// Ports:
//   clk, rst_n               clock, asynchronous active-low reset
//   in_valid/in_ready        operand beat handshake
//   in_a, in_b               operands (WIDTH bits)
//   in_s                     1 = unsigned compare, 0 = two's-complement compare
//   in_last                  final beat of a frame
//   out_valid/out_ready      result handshake
//   out_g/out_e/out_l        one-hot A>B / A==B / A<B
//   out_last                 in_last carried with the beat
//   sum_valid                one-cycle frame-summary pulse (no backpressure)
//   sum_gt/sum_eq/sum_lt     frame tallies, valid with sum_valid, held between pulses
module cmp_stream #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_s,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_g,
  output logic             out_e,
  output logic             out_l,
  output logic             out_last,
  output logic             sum_valid,
  output logic [CNT_W-1:0] sum_gt,
  output logic [CNT_W-1:0] sum_eq,
  output logic [CNT_W-1:0] sum_lt
);

  localparam int unsigned XW = WIDTH + 1;

  logic          s1_v_q;
  logic [XW-1:0] s1_a_q, s1_b_q;
  logic          s1_last_q;
  logic          s2_v_q;
  logic          s2_g_q, s2_e_q, s2_l_q, s2_last_q;
  logic          s1_adv, s2_adv;

  // Zero-extend for unsigned, sign-extend for signed; the extended values are then
  // compared as signed, which orders both modes correctly.
  function automatic logic [XW-1:0] ext(input logic [WIDTH-1:0] x, input logic uns);
    return uns ? {1'b0, x} : {x[WIDTH-1], x};
  endfunction

  assign s2_adv   = !s2_v_q || out_ready;
  assign s1_adv   = !s1_v_q || s2_adv;
  // Held low while in reset so no beat is offered an accept during reset.
  assign in_ready = s1_adv && rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q    <= 1'b0;
      s1_a_q    <= '0;
      s1_b_q    <= '0;
      s1_last_q <= 1'b0;
    end else if (s1_adv) begin
      s1_v_q <= in_valid;
      if (in_valid) begin
        s1_a_q    <= ext(in_a, in_s);
        s1_b_q    <= ext(in_b, in_s);
        s1_last_q <= in_last;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v_q    <= 1'b0;
      s2_g_q    <= 1'b0;
      s2_e_q    <= 1'b0;
      s2_l_q    <= 1'b0;
      s2_last_q <= 1'b0;
    end else if (s2_adv) begin
      s2_v_q <= s1_v_q;
      if (s1_v_q) begin
        s2_g_q    <= $signed(s1_a_q) > $signed(s1_b_q);
        s2_e_q    <= s1_a_q == s1_b_q;
        s2_l_q    <= $signed(s1_a_q) < $signed(s1_b_q);
        s2_last_q <= s1_last_q;
      end
    end
  end

  assign out_valid = s2_v_q;
  assign out_g     = s2_g_q;
  assign out_e     = s2_e_q;
  assign out_l     = s2_l_q;
  assign out_last  = s2_last_q;

`ifdef CMP_TALLY_EN
  logic             out_fire;
  logic [CNT_W-1:0] cnt_gt_q, cnt_eq_q, cnt_lt_q;
  logic [CNT_W-1:0] cnt_gt_d, cnt_eq_d, cnt_lt_d;
  logic [CNT_W-1:0] gt_inc, eq_inc, lt_inc;
  logic [CNT_W-1:0] sum_gt_q, sum_eq_q, sum_lt_q;
  logic [CNT_W-1:0] sum_gt_d, sum_eq_d, sum_lt_d;
  logic             sum_valid_q, sum_valid_d;

  assign out_fire = s2_v_q && out_ready;

  // Saturating increment of the counter that matches the current result.
  assign gt_inc = (s2_g_q && cnt_gt_q != '1) ? cnt_gt_q + 1'b1 : cnt_gt_q;
  assign eq_inc = (s2_e_q && cnt_eq_q != '1) ? cnt_eq_q + 1'b1 : cnt_eq_q;
  assign lt_inc = (s2_l_q && cnt_lt_q != '1) ? cnt_lt_q + 1'b1 : cnt_lt_q;

  always_comb begin
    cnt_gt_d    = cnt_gt_q;
    cnt_eq_d    = cnt_eq_q;
    cnt_lt_d    = cnt_lt_q;
    sum_gt_d    = sum_gt_q;
    sum_eq_d    = sum_eq_q;
    sum_lt_d    = sum_lt_q;
    sum_valid_d = 1'b0;
    if (out_fire) begin
      if (s2_last_q) begin
        // Publish totals including this beat and start the next frame from zero.
        sum_gt_d    = gt_inc;
        sum_eq_d    = eq_inc;
        sum_lt_d    = lt_inc;
        sum_valid_d = 1'b1;
        cnt_gt_d    = '0;
        cnt_eq_d    = '0;
        cnt_lt_d    = '0;
      end else begin
        cnt_gt_d = gt_inc;
        cnt_eq_d = eq_inc;
        cnt_lt_d = lt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_gt_q    <= '0;
      cnt_eq_q    <= '0;
      cnt_lt_q    <= '0;
      sum_gt_q    <= '0;
      sum_eq_q    <= '0;
      sum_lt_q    <= '0;
      sum_valid_q <= 1'b0;
    end else begin
      cnt_gt_q    <= cnt_gt_d;
      cnt_eq_q    <= cnt_eq_d;
      cnt_lt_q    <= cnt_lt_d;
      sum_gt_q    <= sum_gt_d;
      sum_eq_q    <= sum_eq_d;
      sum_lt_q    <= sum_lt_d;
      sum_valid_q <= sum_valid_d;
    end
  end

  assign sum_valid = sum_valid_q;
  assign sum_gt    = sum_gt_q;
  assign sum_eq    = sum_eq_q;
  assign sum_lt    = sum_lt_q;
`else
  assign sum_valid = 1'b0;
  assign sum_gt    = '0;
  assign sum_eq    = '0;
  assign sum_lt    = '0;
`endif

endmodule

// File: tb/tb_cmp_stream.sv
// Self-checking bench for cmp_stream. A reference model (expected-beat queue with
// integer compare, occupancy-based handshake expectations and raw frame tallies)
// checks a WIDTH=8 instance, plus a CNT_W=2 instance sharing the same stimulus for
// saturation of the summary counters.
module tb_cmp_stream;
  localparam int unsigned W   = 8;
  localparam int unsigned CW  = 16;
  localparam int unsigned CW2 = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0, in_s = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [W-1:0]  in_a = '0, in_b = '0;

  logic          in_ready, out_valid, out_g, out_e, out_l, out_last, sum_valid;
  logic [CW-1:0] sum_gt, sum_eq, sum_lt;

  logic           x_in_ready, x_out_valid, x_out_g, x_out_e, x_out_l, x_out_last, x_sum_valid;
  logic [CW2-1:0] x_sum_gt, x_sum_eq, x_sum_lt;

  always #5 clk = ~clk;

  cmp_stream #(.WIDTH(W), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a),
    .in_b(in_b), .in_s(in_s), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_g(out_g), .out_e(out_e), .out_l(out_l),
    .out_last(out_last), .sum_valid(sum_valid), .sum_gt(sum_gt), .sum_eq(sum_eq),
    .sum_lt(sum_lt)
  );

  cmp_stream #(.WIDTH(W), .CNT_W(CW2)) u_sat (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(x_in_ready), .in_a(in_a),
    .in_b(in_b), .in_s(in_s), .in_last(in_last), .out_valid(x_out_valid),
    .out_ready(out_ready), .out_g(x_out_g), .out_e(x_out_e), .out_l(x_out_l),
    .out_last(x_out_last), .sum_valid(x_sum_valid), .sum_gt(x_sum_gt),
    .sum_eq(x_sum_eq), .sum_lt(x_sum_lt)
  );

  typedef struct {
    logic [3:0] res;  // {g, e, l, last}
    int         acc;  // cycle number at acceptance
  } beat_t;

  beat_t      q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         tg = 0, te = 0, tl = 0;  // raw tallies of the current frame
  int         hg = 0, he = 0, hl = 0;  // raw tallies of the last published frame
  logic       sum_pend = 1'b0;
  logic       prev_stall = 1'b0;
  logic [3:0] prev_out = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic int opval(input logic [W-1:0] x, input logic uns);
    return uns ? int'(x) : int'($signed(x));
  endfunction

  function automatic int sat(input int x, input int unsigned cw);
    int lim;
    lim = (1 << cw) - 1;
    return (x > lim) ? lim : x;
  endfunction

  // One clock cycle: check the state left by the previous edge, drive new inputs,
  // update the model with the transfers that the coming edge will perform.
  task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic s, input logic last, input logic ordy);
    logic in_fire, out_fire;
    beat_t bt;
    int ia, ib;
    @(negedge clk);
    check_eq("out_valid", out_valid, q.size() > 0 && (cyc - q[0].acc) >= 2);
    if (out_valid && q.size() > 0)
      check_eq("out_result", {out_g, out_e, out_l, out_last}, q[0].res);
    if (prev_stall)
      check_eq("stall_hold", {out_valid, out_g, out_e, out_l, out_last}, {1'b1, prev_out});
`ifdef CMP_TALLY_EN
    check_eq("sum_valid", sum_valid, sum_pend);
    check_eq("sum_tally", {sum_gt, sum_eq, sum_lt}, {16'(hg), 16'(he), 16'(hl)});
    check_eq("sat_valid", x_sum_valid, sum_pend);
    check_eq("sat_tally", {x_sum_gt, x_sum_eq, x_sum_lt},
             {2'(sat(hg, CW2)), 2'(sat(he, CW2)), 2'(sat(hl, CW2))});
`else
    check_eq("sum_tied", {sum_valid, sum_gt, sum_eq, sum_lt}, '0);
`endif
    sum_pend  = 1'b0;
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_s      = s;
    in_last   = last;
    out_ready = ordy;
    #1;
    check_eq("in_ready", in_ready, q.size() < 2 || ordy);
    in_fire  = in_valid && in_ready;
    out_fire = out_valid && out_ready;
    prev_stall = out_valid && !out_ready;
    prev_out   = {out_g, out_e, out_l, out_last};
    if (out_fire && q.size() > 0) begin
      bt = q.pop_front();
      tg += int'(bt.res[3]);
      te += int'(bt.res[2]);
      tl += int'(bt.res[1]);
      if (bt.res[0]) begin
        hg = tg; he = te; hl = tl;
        tg = 0; te = 0; tl = 0;
        sum_pend = 1'b1;
      end
    end
    if (in_fire) begin
      ia = opval(a, s);
      ib = opval(b, s);
      bt.res = {ia > ib, ia == ib, ia < ib, last};
      bt.acc = cyc;
      q.push_back(bt);
    end
    @(posedge clk);
    cyc++;
  endtask

  initial begin
    // Reset state.
    #3;
    check_eq("rst_out_valid", out_valid, 1'b0);
    check_eq("rst_in_ready", in_ready, 1'b0);
    check_eq("rst_outs", {out_g, out_e, out_l, out_last}, 4'b0);
    check_eq("rst_sum", {sum_valid, sum_gt, sum_eq, sum_lt}, '0);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Mode-dependent directed compares, one frame of five beats.
    step(1'b1, 8'hFF, 8'h01, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'hFF, 8'h01, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h80, 8'h80, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h80, 8'h80, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h7F, 8'h80, 1'b0, 1'b1, 1'b1);
    // Frame G,G,E,L.
    step(1'b1, 8'h05, 8'h02, 1'b1, 1'b0, 1'b1);
    step(1'b1, 8'h03, 8'hFE, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h44, 8'h44, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h01, 8'h09, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Stall with in_valid held high for 5 cycles, then release.
    for (int i = 0; i < 5; i++)
      step(1'b1, 8'(i * 17), 8'(40), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      step(1'b1, 8'(i * 29), 8'(40), 1'b0, i == 3, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Five G beats in one frame (saturates the CNT_W=2 instance), then back-to-back lasts.
    for (int i = 0; i < 5; i++) step(1'b1, 8'd9, 8'd3, 1'b1, i == 4, 1'b1);
    step(1'b1, 8'd1, 8'd1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'd1, 8'd2, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Reset mid-frame with two beats in flight.
    step(1'b1, 8'd7, 8'd7, 1'b1, 1'b0, 1'b0);
    step(1'b1, 8'd8, 8'd7, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("midrst_out_valid", out_valid, 1'b0);
    check_eq("midrst_in_ready", in_ready, 1'b0);
    check_eq("midrst_sum_valid", sum_valid, 1'b0);
    q.delete();
    tg = 0; te = 0; tl = 0;
    hg = 0; he = 0; hl = 0;
    sum_pend   = 1'b0;
    prev_stall = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    step(1'b1, 8'd33, 8'd33, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      logic [W-1:0] ra, rb;
      ra = 8'($urandom);
      rb = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      step($urandom_range(0, 3) != 0, ra, rb, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 3) != 0);
    end
    for (int i = 0; i < 6; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
    check_eq("drained", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmp_stream.md
# cmp_stream

Parametrised, pipelined magnitude comparator with a valid/ready stream interface, a per-operation signed/unsigned mode bit, and optional per-frame result tallies. It is the next-generation comparator. It takes an operand pair per beat and returns a one-hot greater/equal/less result two cycles later. Full backpressure is supported. It sits between operand producers and the decision/statistics logic downstream.

## Interface
- WIDTH, 8, operand width in bits (>= 2)
- CNT_W, 16, width of each tally counter (>= 2)

- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_s  input  1  mode: 1 = unsigned compare, 0 = two's-complement compare
- in_last  input  1  final beat of a frame
- out_valid  output  1  result valid
- out_ready  input  1  downstream accepts result
- out_g / out_e / out_l  output  1 each  A>B / A==B / A<B; exactly one high when out_valid
- out_last  output  1  in_last carried with the beat
- sum_valid  output  1  one-cycle frame-summary pulse
- sum_gt / sum_eq / sum_lt  output  CNT_W each  frame tallies, valid with sum_valid

## Operation
- Transfers occur only when valid && ready on the same rising edge.
- Stage 1 (S1) registers the operands extended to WIDTH+1 bits (in_s=1: zero-extend; in_s=0: sign-extend), plus in_last. It also sets s1_v.
- Stage 2 (S2) registers the comparison of the extended operands as signed WIDTH+1 values. It produces out_g/out_e/out_l and out_last. Its valid bit is out_valid.
- Advance rules:
  - s2_adv = !out_valid || out_ready
  - s1_adv = !s1_v || s2_adv
  - in_ready = s1_adv (combinational; no path from in_valid)
- While out_valid && !out_ready, all out_* signals hold stable.
- The pipeline holds at most 2 beats. Beat order is preserved. No beat is dropped or duplicated.
- Tally: on each output transfer, the counter matching the result increments. Each counter saturates at 2^CNT_W-1.
- Frame summary: on an output transfer with out_last=1:
  - The next cycle, sum_valid=1 for exactly one cycle.
  - sum_* show the totals including that final beat.
  - All counters return to 0, and the following beat starts a new frame.
- sum_valid has no backpressure. sum_* hold their last values between pulses.
- Back-to-back last beats give back-to-back sum_valid pulses, each with a tally of 1.

## Timing
- Reset (rst_n low, asynchronous):
  - out_valid, s1_v, out_g/e/l, out_last, sum_valid = 0
  - sum_* = 0 and all counters = 0
  - in_ready = 0 while rst_n is low
- First cycle after release: in_ready=1.
- Latency: a beat accepted at edge N gives out_valid=1 after edge N+1, when out_ready was high at N+1.
- Throughput: 1 beat/cycle with out_ready held high.
- Reset asserted mid-frame discards in-flight beats and partial tallies. No sum_valid is produced for that frame.
- Mode is per beat; alternating in_s on consecutive beats is legal.

## Configuration
- CMP_TALLY_EN defined: tally counters and frame-summary logic are present as described above.
- CMP_TALLY_EN undefined:
  - No counters are built. sum_valid and sum_* are tied to 0.
  - in_last is still carried to out_last.
  - Compare datapath and handshake are unchanged.

## Test plan
- WIDTH=8, in_a=8'hFF, in_b=8'h01: with in_s=1 -> out_g=1; with in_s=0 -> out_l=1 (-1 < 1). Result appears 2 cycles after acceptance.
- in_a=in_b=8'h80 in both modes -> out_e=1. in_a=8'h7F, in_b=8'h80, in_s=0 -> out_g=1.
- Streaming with out_ready low for 5 cycles and in_valid held high:
  - in_ready drops after 2 beats are accepted.
  - out_* stay stable while stalled.
  - After release, all beats emerge in order with no loss.
- Frame G,G,E,L with last on the 4th beat -> one sum_valid pulse with sum_gt=2, sum_eq=1, sum_lt=1. The next frame's tallies start from 0.
- CNT_W=2, a frame of 5 G beats -> sum_gt=3 (saturated), sum_eq=0, sum_lt=0.
- rst_n pulsed low mid-frame with 2 beats in flight:
  - out_valid=0 immediately and no sum_valid.
  - The next frame of 1 E beat gives sum_eq=1.
